// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder memory-side responder.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Size encoding matches the MDR size select of the datapath.
    localparam logic [1:0] SIZE_WORD = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_BYTE = 2'd2;
    localparam logic [1:0] SIZE_RSVD = 2'd3;

    function automatic logic size_is_reserved(input logic [1:0] size);
        return (size == SIZE_RSVD);
    endfunction

endpackage

// File: rtl/mem_resp_lane.sv
// Byte-lane merge for writes and zero-extending extraction for reads (little-endian lanes).
module mem_resp_lane
    import mem_resp_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    output logic [31:0] merged,
    output logic [31:0] rdata
);

    // Word ignores offset, half uses offset[1] only, byte uses both bits.
    always_comb begin
        merged = old_word;
        rdata  = 32'd0;
        case (size)
            SIZE_WORD: begin
                merged = wdata;
                rdata  = old_word;
            end
            SIZE_HALF: begin
                if (offset[1]) begin
                    merged[31:16] = wdata[15:0];
                    rdata         = {16'd0, old_word[31:16]};
                end else begin
                    merged[15:0] = wdata[15:0];
                    rdata        = {16'd0, old_word[15:0]};
                end
            end
            SIZE_BYTE: begin
                merged[{offset, 3'b000} +: 8] = wdata[7:0];
                rdata = {24'd0, old_word[{offset, 3'b000} +: 8]};
            end
            default: begin
                merged = old_word;
                rdata  = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder with programmable wait states and a single-cycle Ready pulse.
// Optional alignment checking is enabled by defining MEM_RESP_ALIGN_CHECK_EN.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        Wr,
    input  logic [1:0]  Size,
    input  logic [31:0] Address,
    input  logic [31:0] Datain,
    output logic [31:0] Dataout,
    output logic        Ready,
    output logic        Busy,
    output logic        Err
);

    localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [31:0] LIMIT    = 32'(DEPTH * 4);

    state_t      state_r, state_s;
    logic [3:0]  count_r;
    logic        wr_r;
    logic [1:0]  size_r;
    logic [31:0] addr_r, wdata_r;
    logic [31:0] dout_r;
    logic        ready_r, err_r;
    logic [31:0] mem_r [DEPTH];

    logic        accept_s, enter_resp_s;
    logic        sel_wr_s;
    logic [1:0]  sel_size_s;
    logic [31:0] sel_addr_s, sel_wdata_s;
    logic [IDX_W-1:0] idx_s;
    logic        align_err_s, err_s;
    logic [31:0] old_s, merged_s, rdata_s;

    // With zero wait states the access completes on the capture edge, so use live inputs in IDLE.
    assign sel_wr_s    = (state_r == ST_IDLE) ? Wr      : wr_r;
    assign sel_size_s  = (state_r == ST_IDLE) ? Size    : size_r;
    assign sel_addr_s  = (state_r == ST_IDLE) ? Address : addr_r;
    assign sel_wdata_s = (state_r == ST_IDLE) ? Datain  : wdata_r;

    assign idx_s = sel_addr_s[IDX_W+1:2];
    assign old_s = mem_r[idx_s];

`ifdef MEM_RESP_ALIGN_CHECK_EN
    assign align_err_s = ((sel_size_s == SIZE_WORD) && (sel_addr_s[1:0] != 2'd0)) ||
                         ((sel_size_s == SIZE_HALF) && sel_addr_s[0]);
`else
    assign align_err_s = 1'b0;
`endif

    assign err_s = (sel_addr_s >= LIMIT) || size_is_reserved(sel_size_s) || align_err_s;

    mem_resp_lane u_lane (
        .old_word (old_s),
        .wdata    (sel_wdata_s),
        .size     (sel_size_s),
        .offset   (sel_addr_s[1:0]),
        .merged   (merged_s),
        .rdata    (rdata_s)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; enter_resp_s marks the edge on which the access takes effect.
    always_comb begin
        state_s      = state_r;
        accept_s     = 1'b0;
        enter_resp_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (Req) begin
                    accept_s = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s      = ST_RESP;
                        enter_resp_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (count_r == 4'd0) begin
                    state_s      = ST_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Request capture, wait counter and registered response outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_r <= 4'd0;
            wr_r    <= 1'b0;
            size_r  <= 2'd0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
            dout_r  <= 32'd0;
            ready_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                wr_r    <= Wr;
                size_r  <= Size;
                addr_r  <= Address;
                wdata_r <= Datain;
                count_r <= WAIT_LOAD;
            end else if ((state_r == ST_WAIT) && (count_r != 4'd0)) begin
                count_r <= count_r - 4'd1;
            end
            ready_r <= enter_resp_s;
            if (enter_resp_s) begin
                err_r <= err_s;
                if (!sel_wr_s) begin
                    dout_r <= err_s ? 32'd0 : rdata_s;
                end
            end else begin
                err_r <= 1'b0;
            end
        end
    end

    // Storage is not reset; an erroring or reset-aborted write leaves it untouched.
    always_ff @(posedge Clk) begin
        if (!Reset && enter_resp_s && sel_wr_s && !err_s) begin
            mem_r[idx_s] <= merged_s;
        end
    end

    assign Busy    = (state_r != ST_IDLE);
    assign Ready   = ready_r;
    assign Err     = err_r;
    assign Dataout = dout_r;

endmodule

// File: tb/tb_mem_responder.sv
// Randomised plus directed bench for mem_responder, with WAIT_STATES=1 and WAIT_STATES=0 instances.
module tb_mem_responder;

    localparam int DEPTH = 64;

    logic        clk;
    logic        rst, req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [31:0] dout [2];
    logic [1:0]  ready, busy, err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(1)) u_ws1 (
        .Clk(clk), .Reset(rst), .Req(req), .Wr(wr), .Size(size), .Address(addr),
        .Datain(wdata), .Dataout(dout[0]), .Ready(ready[0]), .Busy(busy[0]), .Err(err[0]));

    mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
        .Clk(clk), .Reset(rst), .Req(req), .Wr(wr), .Size(size), .Address(addr),
        .Datain(wdata), .Dataout(dout[1]), .Ready(ready[1]), .Busy(busy[1]), .Err(err[1]));

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level reference: one memory image and a response timeline per instance.
    int          ws_m [2] = '{1, 0};
    logic [31:0] mem_m [2][DEPTH];
    bit          busy_m [2];
    int          resp_e [2];
    bit          t_wr [2];
    logic [1:0]  t_size [2];
    logic [31:0] t_addr [2], t_data [2];
    logic [31:0] dout_m [2];
    bit          ready_m [2], err_m [2];
    bit          last_err [2];
    int          ready_cnt [2];
    int          edge_n = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_err(input logic [1:0] sz, input logic [31:0] a);
        bit e;
        e = (a >= 32'(DEPTH * 4)) || (sz == 2'd3);
`ifdef MEM_RESP_ALIGN_CHECK_EN
        if ((sz == 2'd0) && (a[1:0] != 2'd0)) e = 1'b1;
        if ((sz == 2'd1) && a[0]) e = 1'b1;
`endif
        return e;
    endfunction

    task automatic ref_access(input int d);
        int nb, base, idx;
        logic [31:0] w, r;
        nb   = (t_size[d] == 2'd0) ? 4 : (t_size[d] == 2'd1) ? 2 : 1;
        base = (t_size[d] == 2'd0) ? 0 : (t_size[d] == 2'd1) ? 2 * int'(t_addr[d][1]) : int'(t_addr[d][1:0]);
        ready_m[d] = 1'b1;
        err_m[d]   = ref_err(t_size[d], t_addr[d]);
        if (!err_m[d]) begin
            idx = int'(t_addr[d] >> 2);
            w   = mem_m[d][idx];
            r   = 32'd0;
            for (int i = 0; i < nb; i++) begin
                r = r | (((w >> (8 * (base + i))) & 32'hFF) << (8 * i));
                w[8 * (base + i) +: 8] = t_data[d][8 * i +: 8];
            end
            if (t_wr[d]) mem_m[d][idx] = w;
            else dout_m[d] = r;
        end else if (!t_wr[d]) begin
            dout_m[d] = 32'd0;
        end
    endtask

    task automatic ref_edge();
        for (int d = 0; d < 2; d++) begin
            ready_m[d] = 1'b0;
            if (rst) begin
                busy_m[d] = 1'b0;
                dout_m[d] = 32'd0;
                err_m[d]  = 1'b0;
            end else begin
                if (busy_m[d] && (edge_n == resp_e[d] + 1)) begin
                    busy_m[d] = 1'b0;
                end else if (!busy_m[d] && req) begin
                    busy_m[d] = 1'b1;
                    resp_e[d] = edge_n + ws_m[d];
                    t_wr[d] = wr; t_size[d] = size; t_addr[d] = addr; t_data[d] = wdata;
                end
                if (busy_m[d] && (edge_n == resp_e[d])) ref_access(d);
            end
        end
        edge_n++;
    endtask

    task automatic step();
        @(posedge clk);
        ref_edge();
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("ready ws%0d t%0d", ws_m[d], edge_n), 32'(ready[d]), 32'(ready_m[d]));
            check($sformatf("busy ws%0d t%0d", ws_m[d], edge_n), 32'(busy[d]), 32'(busy_m[d]));
            check($sformatf("dout ws%0d t%0d", ws_m[d], edge_n), dout[d], dout_m[d]);
            if (ready_m[d]) check($sformatf("err ws%0d t%0d", ws_m[d], edge_n), 32'(err[d]), 32'(err_m[d]));
            if (ready[d] === 1'b1) begin
                last_err[d] = err[d];
                ready_cnt[d]++;
            end
        end
    endtask

    task automatic drive(input logic r, input logic q, input logic w, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] dt);
        rst = r; req = q; wr = w; size = s; addr = a; wdata = dt;
        step();
    endtask

    // One request, then two idle cycles with scrambled address/data to show they are ignored.
    task automatic txn(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] dt);
        drive(1'b0, 1'b1, w, s, a, dt);
        repeat (2) drive(1'b0, 1'b0, 1'b0, 2'd0, $urandom, $urandom);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++) mem_m[d][i] = 32'd0;
            busy_m[d] = 1'b0; dout_m[d] = 32'd0; ready_m[d] = 1'b0; err_m[d] = 1'b0;
            resp_e[d] = 0; ready_cnt[d] = 0; last_err[d] = 1'b0;
        end
        repeat (2) drive(1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0);
        for (int d = 0; d < 2; d++) check($sformatf("reset err ws%0d", ws_m[d]), 32'(err[d]), 32'd0);

        for (int i = 0; i < DEPTH; i++) txn(1'b1, 2'd0, 32'(i * 4), $urandom);

        // Word write/read, then byte write and narrow reads.
        txn(1'b1, 2'd0, 32'h10, 32'hDEADBEEF);
        txn(1'b0, 2'd0, 32'h10, 32'd0);
        for (int d = 0; d < 2; d++) check("rd word 0x10", dout[d], 32'hDEADBEEF);
        txn(1'b1, 2'd2, 32'h11, 32'hFFFFFFAB);
        txn(1'b0, 2'd0, 32'h10, 32'd0);
        for (int d = 0; d < 2; d++) check("rd after byte wr", dout[d], 32'hDEADABEF);
        txn(1'b0, 2'd2, 32'h13, 32'd0);
        for (int d = 0; d < 2; d++) check("rd byte 0x13", dout[d], 32'h000000DE);
        txn(1'b0, 2'd1, 32'h12, 32'd0);
        for (int d = 0; d < 2; d++) check("rd half 0x12", dout[d], 32'h0000DEAD);

        // Out-of-range read and reserved-size write, then sweep every word.
        txn(1'b0, 2'd0, 32'h100, 32'd0);
        for (int d = 0; d < 2; d++) begin
            check("oor rd err", 32'(last_err[d]), 32'd1);
            check("oor rd dout", dout[d], 32'd0);
        end
        txn(1'b1, 2'd3, 32'h100, 32'h55);
        for (int d = 0; d < 2; d++) check("rsvd wr err", 32'(last_err[d]), 32'd1);
        for (int i = 0; i < DEPTH; i++) txn(1'b0, 2'd0, 32'(i * 4), 32'd0);

        // Req held high with the address toggling each cycle.
        for (int d = 0; d < 2; d++) ready_cnt[d] = 0;
        for (int i = 0; i < 12; i++) drive(1'b0, 1'b1, 1'b0, 2'd0, (i % 2 == 1) ? 32'h44 : 32'h40, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        check("held req readies ws1", 32'(ready_cnt[0]), 32'd4);
        check("held req readies ws0", 32'(ready_cnt[1]), 32'd6);

        // Reset during the wait cycle of a write.
        txn(1'b1, 2'd0, 32'h20, 32'h0BADF00D);
        drive(1'b0, 1'b1, 1'b1, 2'd0, 32'h20, 32'h12345678);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        for (int d = 0; d < 2; d++) begin
            check("post-reset busy", 32'(busy[d]), 32'd0);
            check("post-reset dout", dout[d], 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        txn(1'b0, 2'd0, 32'h20, 32'd0);
        check("aborted wr ws1", dout[0], 32'h0BADF00D);
        check("completed wr ws0", dout[1], 32'h12345678);

        // Misaligned word read.
        txn(1'b1, 2'd0, 32'h10, 32'hCAFEF00D);
        txn(1'b0, 2'd0, 32'h12, 32'd0);
        for (int d = 0; d < 2; d++) begin
`ifdef MEM_RESP_ALIGN_CHECK_EN
            check("misaligned err", 32'(last_err[d]), 32'd1);
            check("misaligned dout", dout[d], 32'd0);
`else
            check("misaligned err", 32'(last_err[d]), 32'd0);
            check("misaligned dout", dout[d], 32'hCAFEF00D);
`endif
        end

        // Random traffic, including stray resets and bad addresses/sizes.
        for (int i = 0; i < 900; i++) begin
            int sel;
            logic [31:0] a;
            sel = $urandom_range(0, 9);
            a = (sel == 0) ? 32'h100 + 32'($urandom_range(0, 255)) :
                (sel == 1) ? 32'($urandom) : 32'($urandom_range(0, 255));
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                  2'($urandom_range(0, 3)), a, $urandom);
        end
        drive(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        for (int i = 0; i < DEPTH; i++) txn(1'b0, 2'd0, 32'(i * 4), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
